// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data access with a bounded data-priority streak
module mem_port_arbiter #(
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_read,
    input  logic [31:0] inst_addr,
    output logic        inst_resp,
    output logic [31:0] inst_rdata,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [3:0]  data_mbe,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_resp,
    output logic [31:0] data_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_mbe,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_resp,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, INST, DATA} state_t;
    state_t state, state_next;
    logic [3:0] streak;
    logic data_req, starving;
    always_comb begin
        data_req = data_read | data_write;
        starving = inst_read & (streak == 4'(MAX_DATA_STREAK));
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            streak    <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_mbe   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && state_next == INST) begin
                streak    <= '0;
                mem_read  <= 1'b1;
                mem_write <= 1'b0;
                mem_mbe   <= 4'b1111;
                mem_addr  <= inst_addr;
            end
            if (state == IDLE && state_next == DATA) begin
                if (inst_read && streak != 4'(MAX_DATA_STREAK))
                    streak <= streak + 4'd1;
                mem_read  <= ~data_write;
                mem_write <= data_write;
                mem_mbe   <= data_write ? data_mbe : 4'b1111;
                mem_addr  <= data_addr;
                mem_wdata <= data_wdata;
            end
            if (state != IDLE && mem_resp) begin
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
            end
        end
    end
    always_comb begin
        state_next = state;
        if (state == IDLE)
            state_next = (data_req && !starving) ? DATA : inst_read ? INST : data_req ? DATA : IDLE;
        else if (mem_resp)
            state_next = IDLE;
    end
    always_comb begin
        inst_resp  = mem_resp & (state == INST);
        data_resp  = mem_resp & (state == DATA);
        inst_rdata = mem_rdata;
        data_rdata = mem_rdata;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized requesters and memory checked against a transaction-level arbitration model
module tb_mem_port_arbiter;
    localparam int MAX = 4;
    logic        clk = 1'b0;
    logic        rst;
    logic        inst_read, inst_resp, data_read, data_write, data_resp;
    logic        mem_read, mem_write, mem_resp;
    logic [31:0] inst_addr, inst_rdata, data_addr, data_wdata, data_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  data_mbe, mem_mbe;
    int total = 0, bad = 0;
    int owner = 0, cnt = 0, streak = 0, p_inst = 0, p_data = 0, lat_min = 0, lat_max = 3;
    int run = 0, seen_inst = 0, sat_phase = 0;
    bit inst_pend = 0, data_pend = 0;
    logic e_read = 0, e_write = 0;
    logic [3:0]  e_mbe = '0;
    logic [31:0] e_addr = '0, e_wdata = '0;

    mem_port_arbiter #(.MAX_DATA_STREAK(MAX)) dut (
        .clk(clk), .rst(rst),
        .inst_read(inst_read), .inst_addr(inst_addr), .inst_resp(inst_resp), .inst_rdata(inst_rdata),
        .data_read(data_read), .data_write(data_write), .data_mbe(data_mbe), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_resp(data_resp), .data_rdata(data_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_mbe(mem_mbe), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        bit [1:0] rw;
        @(posedge clk);
        #1;
        check("mem_read", mem_read, e_read);
        check("mem_write", mem_write, e_write);
        if (e_read || e_write) begin
            check("mem_addr", mem_addr, e_addr);
            check("mem_mbe", mem_mbe, e_mbe);
            if (e_write) check("mem_wdata", mem_wdata, e_wdata);
        end
        mem_rdata = $urandom;
        mem_resp  = (owner != 0) ? (cnt == 0) : ($urandom % 8 == 0);
        if (owner == 1 && $urandom % 2 == 1) inst_addr = $urandom;
        if (owner == 2 && $urandom % 2 == 1) begin
            data_addr  = $urandom;
            data_wdata = $urandom;
            data_mbe   = 4'($urandom);
        end
        if (!inst_pend) begin
            inst_read = 1'b0;
            if ($urandom % 100 < p_inst) begin
                inst_pend = 1;
                inst_read = 1'b1;
                inst_addr = $urandom;
            end
        end
        if (!data_pend) begin
            data_read  = 1'b0;
            data_write = 1'b0;
            if ($urandom % 100 < p_data) begin
                data_pend  = 1;
                rw         = 2'($urandom);
                data_read  = (rw != 2'd1);
                data_write = rw[0];
                data_addr  = $urandom;
                data_wdata = $urandom;
                data_mbe   = 4'($urandom);
            end
        end
        #1;
        check("inst_resp", inst_resp, mem_resp && owner == 1);
        check("data_resp", data_resp, mem_resp && owner == 2);
        if (mem_resp && owner == 1) check("inst_rdata", inst_rdata, mem_rdata);
        if (mem_resp && owner == 2) check("data_rdata", data_rdata, mem_rdata);
        if (owner != 0) begin
            if (mem_resp) begin
                if (owner == 1) inst_pend = 0; else data_pend = 0;
                owner   = 0;
                e_read  = 0;
                e_write = 0;
            end else cnt--;
        end else if ((data_read || data_write) && !(inst_read && streak == MAX)) begin
            owner = 2;
            if (inst_read && streak < MAX) streak++;
            e_write = data_write;
            e_read  = !data_write;
            e_mbe   = data_write ? data_mbe : 4'hf;
            e_addr  = data_addr;
            e_wdata = data_wdata;
            cnt     = lat_min + int'($urandom % (lat_max - lat_min + 1));
            run++;
        end else if (inst_read) begin
            owner   = 1;
            streak  = 0;
            e_read  = 1;
            e_write = 0;
            e_mbe   = 4'hf;
            e_addr  = inst_addr;
            cnt     = lat_min + int'($urandom % (lat_max - lat_min + 1));
            if (sat_phase != 0 && seen_inst != 0) check("streak_run", run, MAX);
            seen_inst = sat_phase;
            run = 0;
        end
    endtask

    initial begin
        int found;
        rst = 1'b0;
        {inst_read, data_read, data_write, mem_resp} = '0;
        {inst_addr, data_addr, data_wdata, mem_rdata} = '0;
        data_mbe = '0;
        #1;
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_mbe", mem_mbe, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_inst_resp", inst_resp, 0);
        check("rst_data_resp", data_resp, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        p_inst = 40; p_data = 40;
        repeat (400) cycle();
        p_inst = 100; p_data = 100; sat_phase = 1;
        repeat (200) cycle();
        sat_phase = 0;
        p_inst = 20; p_data = 70;
        repeat (300) cycle();
        p_inst = 0; p_data = 100; lat_min = 5; lat_max = 5;
        found = 0;
        for (int i = 0; i < 50 && found == 0; i++) begin
            cycle();
            if (owner == 2 && cnt >= 2) found = 1;
        end
        check("reach_data", found, 1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_mem_read", mem_read, 0);
        check("mid_rst_mem_write", mem_write, 0);
        check("mid_rst_mem_mbe", mem_mbe, 0);
        check("mid_rst_mem_addr", mem_addr, 0);
        check("mid_rst_mem_wdata", mem_wdata, 0);
        check("mid_rst_data_resp", data_resp, 0);
        {inst_read, data_read, data_write} = '0;
        inst_pend = 0; data_pend = 0; owner = 0; streak = 0; run = 0;
        e_read = 0; e_write = 0; p_inst = 0; p_data = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        mem_resp = 1'b1;
        #1;
        check("stale_inst_resp", inst_resp, 0);
        check("stale_data_resp", data_resp, 0);
        @(posedge clk);
        #1;
        mem_resp = 1'b0;
        check("stale_mem_read", mem_read, 0);
        check("stale_mem_write", mem_write, 0);
        lat_min = 0; lat_max = 3; p_inst = 50; p_data = 50;
        repeat (150) cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
